game_control: RTL
=================

# game_control

Control FSM sitting directly upstream of the game datapath. It turns the start button and decoded keyboard moves into the datapath's enable/select/plot strobes and sequences each move: erase, step, collision check, redraw, rate-limit delay. It consumes the datapath flags `timer_done`, `obs_black` and `did_win`. Every `en_*`/`s_*` output connects one-to-one to the datapath port of the same name.

## Interface
- `OBS_COUNT`, default 16: cycles spent in obstacle-draw state; range 1–255.
- `clk` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: level from the start key; the FSM acts on its rising edge.
- `move_valid` in 1: single-cycle pulse; `move_code` is valid.
- `move_code` in 3: 1 up, 2 down, 3 left, 4 right. 0, 5, 6 and 7 are ignored.
- `timer_done` in 1: datapath delay timer expired.
- `obs_black` in 1: target pixel is free. 0 means collision.
- `did_win` in 1: current position is the goal.
- `en_move`/`s_move[2:0]`, `en_timer`/`s_timer`, `en_xpos`/`s_xpos[1:0]`, `en_ypos`/`s_ypos[1:0]`, `en_key`/`s_key[2:0]`, `en_win`/`s_win`, `en_obs`/`s_obs[1:0]`, `s_color`, `plot`: all outputs, driving the datapath.
- `move_count` out 8: accepted moves that were not undone. Saturates at 255.
- `state` out 4: current state, for debug.

## Operation
- Moore FSM. All datapath outputs are decoded combinationally from `state` and the internal latched move `mv_q[2:0]`.
- Any output not listed for a state is 0.
- **RESET**: `en_xpos`=1 with `s_xpos`=0, `en_ypos`=1 with `s_ypos`=0, `en_key`=1 with `s_key`=0, `en_win`=1 with `s_win`=0, `en_timer`=1 with `s_timer`=0, `en_obs`=1 with `s_obs`=0. Clear `obs_cnt`, `move_count` and `mv_q`. Next state is IDLE.
- **IDLE**: on a start rising edge, go to OBS.
- **OBS**: `en_obs`=1, `s_obs`=1, `plot`=1, `s_color`=1. `obs_cnt` increments each cycle. After exactly `OBS_COUNT` cycles in OBS, go to DRAW.
- **WAIT**: a `move_valid` with a legal code does three things. It drives `en_move`=1 and `s_move`=`move_code` in that same cycle, latches `mv_q`, and moves to ERASE. An illegal code or no pulse means stay in WAIT.
- **ERASE**: `plot`=1, `s_color`=0. Next state is STEP.
- **STEP** applies the latched move, then goes to CHECK:
  - up: `en_ypos`=1, `s_ypos`=2.
  - down: `en_ypos`=1, `s_ypos`=1.
  - left: `en_xpos`=1, `s_xpos`=2.
  - right: `en_xpos`=1, `s_xpos`=1.
- **CHECK** samples the flags and decides; if both conditions hold, collision wins:
  - `obs_black`=0: go to UNDO.
  - else `did_win`=1: go to WIN.
  - else: go to DRAW and increment `move_count` (saturating).
- **UNDO**: the inverse of STEP (up↔down, left↔right select swapped). Next state is DRAW.
- **DRAW**: `plot`=1, `s_color`=1, `en_timer`=1, `s_timer`=0. Next state is DELAY.
- **DELAY**: `en_timer`=1, `s_timer`=1. When `timer_done`=1, go to WAIT. `move_valid` is ignored here.
- **WIN**: `en_win`=1, `s_win`=1, `en_key`=1, `s_key`=1, `plot`=1, `s_color`=1. Increment `move_count`. Next state is DONE.
- **DONE**: hold. A start rising edge goes to RESET.
- Start edge detection: register `start` into `start_q`; the edge is `start & ~start_q`. A start edge in any state other than IDLE or DONE is ignored.

## Timing
- When `resetn`=0, the following clear asynchronously: `state`→RESET, `start_q`→0, `obs_cnt`→0, `mv_q`→0, `move_count`→0.
- While in reset, outputs equal the RESET decode. This is intentional, so the datapath initialises during reset.
- Latency from `move_valid` to the first erase plot: 1 cycle.
- Full move without collision: WAIT, ERASE, STEP, CHECK, DRAW, then DELAY for at least 1 cycle. That is 5 cycles plus the timer.
- A collision adds 1 cycle (UNDO).
- `obs_black` and `did_win` are valid in CHECK, one edge after STEP updated the position.
- If reset asserts mid-move (ERASE through DELAY), the move is aborted with no partial `move_count` update. After reset releases, the FSM makes one RESET cycle, then goes to IDLE.
- `move_valid` in the same cycle that DELAY exits is dropped.

## Structure
- Put these in a shared header `game_defs.vh`:
  - state encodings
  - move codes
  - position-select codes `POS_INIT`=0, `POS_INC`=1, `POS_DEC`=2
- One sub-module, `rise_detect`: a 1-bit registered edge detector with async active-low reset, used for `start`.

## Test plan
- **Reset then start**: release `resetn`, pulse `start`. Required response:
  - RESET decode is seen for 1 cycle, then IDLE.
  - OBS lasts 16 cycles with `plot`=1.
  - The FSM then passes through DRAW and ends in WAIT.
- **Right move, no collision**: `move_code`=4 with `obs_black`=1 and `did_win`=0. Required response:
  - ERASE shows `s_color`=0.
  - STEP shows `en_xpos`=1, `s_xpos`=1.
  - DRAW follows, and `move_count` goes 0→1.
- **Up move into obstacle**: `obs_black`=0 in CHECK. Required response:
  - UNDO shows `en_ypos`=1, `s_ypos`=1.
  - `move_count` is unchanged.
- **Win with simultaneous flags**: `did_win`=1 and `obs_black`=0 in CHECK. Required response: UNDO, not WIN. On a later clean move with `did_win`=1, the FSM reaches WIN, then DONE, with `s_win`=1 for one cycle.
- **Rate limit**: pulse `move_valid` during DELAY with `timer_done`=0. Required response: the pulse is ignored, the FSM stays in DELAY, and `en_move` stays 0.
- **Reset mid-move**: assert `resetn`=0 in STEP. Required response: `state` goes to RESET immediately, `move_count`=0, and `mv_q`=0.

Source files
------------

// File: rtl/game_control_pkg.sv
// Shared definitions for the game control FSM: state encodings, move codes
// and the position-select codes understood by the datapath.
package game_control_pkg;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_IDLE  = 4'd1,
        ST_OBS   = 4'd2,
        ST_DRAW  = 4'd3,
        ST_DELAY = 4'd4,
        ST_WAIT  = 4'd5,
        ST_ERASE = 4'd6,
        ST_STEP  = 4'd7,
        ST_CHECK = 4'd8,
        ST_UNDO  = 4'd9,
        ST_WIN   = 4'd10,
        ST_DONE  = 4'd11
    } state_t;

    localparam logic [2:0] MV_UP    = 3'd1;
    localparam logic [2:0] MV_DOWN  = 3'd2;
    localparam logic [2:0] MV_LEFT  = 3'd3;
    localparam logic [2:0] MV_RIGHT = 3'd4;

    localparam logic [1:0] POS_INIT = 2'd0;
    localparam logic [1:0] POS_INC  = 2'd1;
    localparam logic [1:0] POS_DEC  = 2'd2;

    // Codes 1..4 are moves; everything else is ignored.
    function automatic logic is_legal_move(input logic [2:0] code);
        return (code >= MV_UP) && (code <= MV_RIGHT);
    endfunction

endpackage

// File: rtl/game_control_rise_detect.sv
// One-bit registered rising-edge detector with asynchronous active-low reset.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember the previous level of d.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) d_q <= 1'b0;
        else         d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_control.sv
// Control FSM upstream of the game datapath: turns start/move inputs into
// datapath enable/select/plot strobes and sequences each move
// (erase, step, collision check, redraw, rate-limit delay).
//
// Move handshake: move_valid is a single-cycle pulse qualifying move_code.
// There is no ready; a pulse is consumed only when the FSM is in WAIT and the
// code is legal, otherwise it is silently dropped (including during DELAY).
module game_control
    import game_control_pkg::*;
#(
    parameter int unsigned OBS_COUNT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       move_valid,
    input  logic [2:0] move_code,
    input  logic       timer_done,
    input  logic       obs_black,
    input  logic       did_win,
    output logic       en_move,
    output logic [2:0] s_move,
    output logic       en_timer,
    output logic       s_timer,
    output logic       en_xpos,
    output logic [1:0] s_xpos,
    output logic       en_ypos,
    output logic [1:0] s_ypos,
    output logic       en_key,
    output logic [2:0] s_key,
    output logic       en_win,
    output logic       s_win,
    output logic       en_obs,
    output logic [1:0] s_obs,
    output logic       s_color,
    output logic       plot,
    output logic [7:0] move_count,
    output logic [3:0] state
);

    localparam logic [7:0] OBS_LAST = 8'(OBS_COUNT - 1);

    state_t     state_q, state_d;
    logic [7:0] obs_cnt;
    logic [2:0] mv_q;
    logic       start_rise;
    logic       move_accept;

    rise_detect u_start_rise (
        .clk    (clk),
        .resetn (resetn),
        .d      (start),
        .rise   (start_rise)
    );

    assign move_accept = (state_q == ST_WAIT) && move_valid && is_legal_move(move_code);
    assign state       = state_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_RESET;
        else         state_q <= state_d;
    end

    // Obstacle counter, latched move and the saturating move counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            obs_cnt    <= 8'd0;
            mv_q       <= 3'd0;
            move_count <= 8'd0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    obs_cnt    <= 8'd0;
                    mv_q       <= 3'd0;
                    move_count <= 8'd0;
                end
                ST_IDLE: obs_cnt <= 8'd0;
                ST_OBS:  obs_cnt <= obs_cnt + 8'd1;
                ST_WAIT: if (move_accept) mv_q <= move_code;
                ST_CHECK: begin
                    if (obs_black && !did_win && move_count != 8'hFF)
                        move_count <= move_count + 8'd1;
                end
                ST_WIN: if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                default: ;
            endcase
        end
    end

    // Next state and Moore output decode (en_move/s_move follow the accepted pulse).
    always_comb begin
        state_d  = state_q;
        en_move  = 1'b0;
        s_move   = 3'd0;
        en_timer = 1'b0;
        s_timer  = 1'b0;
        en_xpos  = 1'b0;
        s_xpos   = POS_INIT;
        en_ypos  = 1'b0;
        s_ypos   = POS_INIT;
        en_key   = 1'b0;
        s_key    = 3'd0;
        en_win   = 1'b0;
        s_win    = 1'b0;
        en_obs   = 1'b0;
        s_obs    = 2'd0;
        s_color  = 1'b0;
        plot     = 1'b0;
        case (state_q)
            ST_RESET: begin
                en_xpos  = 1'b1;
                en_ypos  = 1'b1;
                en_key   = 1'b1;
                en_win   = 1'b1;
                en_timer = 1'b1;
                en_obs   = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_IDLE: if (start_rise) state_d = ST_OBS;
            ST_OBS: begin
                en_obs  = 1'b1;
                s_obs   = 2'd1;
                plot    = 1'b1;
                s_color = 1'b1;
                if (obs_cnt == OBS_LAST) state_d = ST_DRAW;
            end
            ST_WAIT: begin
                if (move_accept) begin
                    en_move = 1'b1;
                    s_move  = move_code;
                    state_d = ST_ERASE;
                end
            end
            ST_ERASE: begin
                plot    = 1'b1;
                state_d = ST_STEP;
            end
            ST_STEP, ST_UNDO: begin
                // UNDO applies the opposite direction on the same axis.
                case (mv_q)
                    MV_UP:    begin en_ypos = 1'b1; s_ypos = (state_q == ST_STEP) ? POS_DEC : POS_INC; end
                    MV_DOWN:  begin en_ypos = 1'b1; s_ypos = (state_q == ST_STEP) ? POS_INC : POS_DEC; end
                    MV_LEFT:  begin en_xpos = 1'b1; s_xpos = (state_q == ST_STEP) ? POS_DEC : POS_INC; end
                    MV_RIGHT: begin en_xpos = 1'b1; s_xpos = (state_q == ST_STEP) ? POS_INC : POS_DEC; end
                    default: ;
                endcase
                state_d = (state_q == ST_STEP) ? ST_CHECK : ST_DRAW;
            end
            ST_CHECK: begin
                if (!obs_black)   state_d = ST_UNDO;
                else if (did_win) state_d = ST_WIN;
                else              state_d = ST_DRAW;
            end
            ST_DRAW: begin
                plot     = 1'b1;
                s_color  = 1'b1;
                en_timer = 1'b1;
                state_d  = ST_DELAY;
            end
            ST_DELAY: begin
                en_timer = 1'b1;
                s_timer  = 1'b1;
                if (timer_done) state_d = ST_WAIT;
            end
            ST_WIN: begin
                en_win  = 1'b1;
                s_win   = 1'b1;
                en_key  = 1'b1;
                s_key   = 3'd1;
                plot    = 1'b1;
                s_color = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: if (start_rise) state_d = ST_RESET;
            default: state_d = ST_RESET;
        endcase
    end

endmodule
